ser_video_rx: RTL and testbench
===============================

# ser_video_rx

Serial video receiver for the five-wire serial video link (VIDEO_R_SER, VIDEO_G_SER, VIDEO_B_SER, VIDEO_CLK_SER, VIDEO_LAT_SER) that the board's serial video transmitter drives from the 7-bit VIDEO_R/G/B palette output. It oversamples the link in the CLK_24M domain and rebuilds parallel 7-bit RGB pixels with a one-cycle strobe. It also measures pixels per line using idle gaps on the bit clock. It sits on the display/capture side of the link and feeds framebuffer or scaler logic.

## Interface
- BITS, 7: bits per colour channel per pixel; MSB sent first.
- SYNC_STAGES, 2: synchronizer flops on each serial input; minimum 2.
- IDLE_TIMEOUT, 64: CLK_24M cycles without a VIDEO_CLK_SER rising edge that end a line.

- CLK_24M  in  1  sampling clock; sole clock.
- nRESET  in  1  asynchronous, active-low reset.
- VIDEO_R_SER / VIDEO_G_SER / VIDEO_B_SER  in  1 each  serial channel data.
- VIDEO_CLK_SER  in  1  bit clock; data is valid on its rising edge.
- VIDEO_LAT_SER  in  1  word latch; rising edge ends a pixel.
- VIDEO_R / VIDEO_G / VIDEO_B  out  BITS each  last good pixel.
- PIX_STB  out  1  one-cycle pulse: new pixel on VIDEO_R/G/B.
- FRAME_ERR  out  1  one-cycle pulse: malformed word discarded.
- LINE_PIXELS  out  9  pixel count of the last completed line.
- LINE_STB  out  1  one-cycle pulse: LINE_PIXELS updated.

## Operation
- All five serial inputs pass through SYNC_STAGES flops, then one delay flop. Edges are detected combinationally as sync & ~delayed. Every internal action below is registered on that edge.
- **CLK rise:**
  - Each channel shift register shifts left, with the new bit entering the LSB.
  - bitcnt (4-bit) increments and saturates at 15.
  - idlecnt clears.
- **LAT rise:** let n = bitcnt, plus 1 if a CLK rise happens in the same cycle. That bit is shifted in first.
  - If n == BITS: the shift registers load into VIDEO_R/G/B and PIX_STB pulses. pixcnt (9-bit) increments and saturates at 511.
  - Otherwise: FRAME_ERR pulses and the outputs hold.
  - In both cases bitcnt clears. Extra bits (n > BITS) are an error, not truncated.
- **Idle:** idlecnt increments each cycle without a CLK rise and saturates at IDLE_TIMEOUT. On the cycle it reaches IDLE_TIMEOUT:
  - If pixcnt ≠ 0: LINE_PIXELS takes pixcnt, LINE_STB pulses, and pixcnt clears.
  - If bitcnt ≠ 0: FRAME_ERR pulses and bitcnt clears, which discards the partial word.
  - It fires once per idle period and re-arms only after the next CLK rise.
- **Idle and LAT in the same cycle:** the LAT rule applies first. The pixel counts in the line being closed.
- **Reset values:**
  - Outputs: VIDEO_R/G/B = 0, PIX_STB = 0, FRAME_ERR = 0, LINE_PIXELS = 0, LINE_STB = 0.
  - Internal: bitcnt = 0, pixcnt = 0, shift registers = 0, sync/delay flops = 0.
  - idlecnt resets to IDLE_TIMEOUT, so no LINE_STB is issued before the first CLK rise.
- **Reset mid-word:** the partial word is lost and no strobe is issued. Reception resumes cleanly at the next full word.

## Timing
- Input requirements:
  - VIDEO_CLK_SER high ≥ 2 and low ≥ 2 CLK_24M cycles.
  - Data stable from 2 cycles before to 2 cycles after each CLK rise.
  - VIDEO_LAT_SER high ≥ 2 cycles.
- Let k be the first CLK_24M edge that samples LAT high. PIX_STB, FRAME_ERR and the new VIDEO_R/G/B are visible after edge k+SYNC_STAGES, i.e. latency SYNC_STAGES+1 edges including k.
- LINE_STB is raised by the edge on which idlecnt reaches IDLE_TIMEOUT. That is IDLE_TIMEOUT cycles after the registered CLK rise, plus the synchronizer latency.
- All strobes are high for exactly one cycle. Two consecutive PIX_STBs are at least 2·BITS·2 cycles apart under the input rules.

## Test plan
- **Good word:** reset, then shift R=7'h55, G=7'h2A, B=7'h7F MSB-first (7 CLK rises, 4 cycles per bit), then pulse LAT. Expect VIDEO_R/G/B = 55/2A/7F and a single PIX_STB at k+2. FRAME_ERR stays 0.
- **Short and long words:** 6 bits then LAT, then 8 bits then LAT. Expect two FRAME_ERR pulses, no PIX_STB, and outputs holding the previous pixel. A following good 7-bit word gives a normal PIX_STB.
- **Same-cycle CLK and LAT:** 6 bits, then the 7th CLK rise and LAT rise asserted in the same cycle. Expect PIX_STB with the 7th bit included in the LSB.
- **Line measurement:** send 320 good pixels, then hold CLK idle for 70 cycles. Expect LINE_PIXELS = 320 with one LINE_STB 64 cycles after the last registered CLK rise. Continued idle produces no second LINE_STB. Saturation check: 600 pixels gives LINE_PIXELS = 511.
- **Partial word at idle:** 3 bits then idle for 64 cycles. Expect FRAME_ERR and no LINE_STB if pixcnt = 0.
- **Reset mid-word:** assert nRESET low after 4 bits. All outputs go to 0 immediately, with no strobe. After release, a good 7-bit word gives a normal PIX_STB.

Source files
------------

// File: rtl/ser_video_rx_if.sv
// Serial video link plus the rebuilt pixel/line outputs of the receiver.
// The slave modport is the receiver; the master modport is the link driver / pixel consumer.
interface ser_video_rx_if #(
    parameter int unsigned BITS = 7
);
    logic            VIDEO_R_SER;
    logic            VIDEO_G_SER;
    logic            VIDEO_B_SER;
    logic            VIDEO_CLK_SER;
    logic            VIDEO_LAT_SER;
    logic [BITS-1:0] VIDEO_R;
    logic [BITS-1:0] VIDEO_G;
    logic [BITS-1:0] VIDEO_B;
    logic            PIX_STB;
    logic            FRAME_ERR;
    logic [8:0]      LINE_PIXELS;
    logic            LINE_STB;

    modport master (
        output VIDEO_R_SER, VIDEO_G_SER, VIDEO_B_SER, VIDEO_CLK_SER, VIDEO_LAT_SER,
        input  VIDEO_R, VIDEO_G, VIDEO_B, PIX_STB, FRAME_ERR, LINE_PIXELS, LINE_STB
    );

    modport slave (
        input  VIDEO_R_SER, VIDEO_G_SER, VIDEO_B_SER, VIDEO_CLK_SER, VIDEO_LAT_SER,
        output VIDEO_R, VIDEO_G, VIDEO_B, PIX_STB, FRAME_ERR, LINE_PIXELS, LINE_STB
    );
endinterface

// File: rtl/ser_video_rx.sv
// Oversampling receiver for the serial RGB video link: rebuilds BITS-wide pixels on LAT rises
// and measures pixels per line using idle gaps on the bit clock.
module ser_video_rx #(
    parameter int unsigned BITS         = 7,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input logic           CLK_24M,
    input logic           nRESET,
    ser_video_rx_if.slave vid
);
    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

    // Bit order in the sync chain: {LAT, CLK, B, G, R}.
    logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
    logic [4:0]                  sync_o;
    logic [1:0]                  dly_q;
    logic                        clk_rise, lat_rise, idle_fire;

    logic [BITS-1:0] sr_r_q, sr_r_d, sr_g_q, sr_g_d, sr_b_q, sr_b_d;
    logic [BITS-1:0] vid_r_q, vid_r_d, vid_g_q, vid_g_d, vid_b_q, vid_b_d;
    logic [3:0]      bitcnt_q, bitcnt_d, bitcnt_clk;
    logic [8:0]      pixcnt_q, pixcnt_d;
    logic [8:0]      line_pixels_q, line_pixels_d;
    logic [IW-1:0]   idlecnt_q, idlecnt_d;
    logic            pix_stb_q, pix_stb_d;
    logic            frame_err_q, frame_err_d;
    logic            line_stb_q, line_stb_d;

    always_comb begin
        sync_d[0] = {vid.VIDEO_LAT_SER, vid.VIDEO_CLK_SER, vid.VIDEO_B_SER, vid.VIDEO_G_SER,
                     vid.VIDEO_R_SER};
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_o   = sync_q[SYNC_STAGES-1];
    assign clk_rise = sync_o[3] & ~dly_q[0];
    assign lat_rise = sync_o[4] & ~dly_q[1];

    always_comb begin
        sr_r_d        = sr_r_q;
        sr_g_d        = sr_g_q;
        sr_b_d        = sr_b_q;
        bitcnt_clk    = bitcnt_q;
        vid_r_d       = vid_r_q;
        vid_g_d       = vid_g_q;
        vid_b_d       = vid_b_q;
        pix_stb_d     = 1'b0;
        frame_err_d   = 1'b0;
        line_stb_d    = 1'b0;
        line_pixels_d = line_pixels_q;
        pixcnt_d      = pixcnt_q;
        idlecnt_d     = idlecnt_q;
        idle_fire     = 1'b0;

        if (clk_rise) begin
            sr_r_d     = {sr_r_q[BITS-2:0], sync_o[0]};
            sr_g_d     = {sr_g_q[BITS-2:0], sync_o[1]};
            sr_b_d     = {sr_b_q[BITS-2:0], sync_o[2]};
            bitcnt_clk = (bitcnt_q == 4'd15) ? 4'd15 : bitcnt_q + 4'd1;
            idlecnt_d  = '0;
        end else if (idlecnt_q < IW'(IDLE_TIMEOUT)) begin
            idlecnt_d = idlecnt_q + 1'b1;
            idle_fire = (idlecnt_q == IW'(IDLE_TIMEOUT - 1));
        end
        bitcnt_d = bitcnt_clk;

        // A bit clocked in the same cycle as LAT already counts toward this word.
        if (lat_rise) begin
            bitcnt_d = '0;
            if (bitcnt_clk == 4'(BITS)) begin
                vid_r_d   = sr_r_d;
                vid_g_d   = sr_g_d;
                vid_b_d   = sr_b_d;
                pix_stb_d = 1'b1;
                pixcnt_d  = (pixcnt_q == 9'd511) ? 9'd511 : pixcnt_q + 9'd1;
            end else begin
                frame_err_d = 1'b1;
            end
        end

        // Evaluated after LAT so a pixel landing on the timeout edge joins the closing line.
        if (idle_fire) begin
            if (pixcnt_d != '0) begin
                line_pixels_d = pixcnt_d;
                line_stb_d    = 1'b1;
                pixcnt_d      = '0;
            end
            if (bitcnt_d != '0) begin
                frame_err_d = 1'b1;
                bitcnt_d    = '0;
            end
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            sync_q        <= '0;
            dly_q         <= '0;
            sr_r_q        <= '0;
            sr_g_q        <= '0;
            sr_b_q        <= '0;
            vid_r_q       <= '0;
            vid_g_q       <= '0;
            vid_b_q       <= '0;
            bitcnt_q      <= '0;
            pixcnt_q      <= '0;
            line_pixels_q <= '0;
            idlecnt_q     <= IW'(IDLE_TIMEOUT);
            pix_stb_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            line_stb_q    <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            dly_q         <= sync_o[4:3];
            sr_r_q        <= sr_r_d;
            sr_g_q        <= sr_g_d;
            sr_b_q        <= sr_b_d;
            vid_r_q       <= vid_r_d;
            vid_g_q       <= vid_g_d;
            vid_b_q       <= vid_b_d;
            bitcnt_q      <= bitcnt_d;
            pixcnt_q      <= pixcnt_d;
            line_pixels_q <= line_pixels_d;
            idlecnt_q     <= idlecnt_d;
            pix_stb_q     <= pix_stb_d;
            frame_err_q   <= frame_err_d;
            line_stb_q    <= line_stb_d;
        end
    end

    assign vid.VIDEO_R     = vid_r_q;
    assign vid.VIDEO_G     = vid_g_q;
    assign vid.VIDEO_B     = vid_b_q;
    assign vid.PIX_STB     = pix_stb_q;
    assign vid.FRAME_ERR   = frame_err_q;
    assign vid.LINE_PIXELS = line_pixels_q;
    assign vid.LINE_STB    = line_stb_q;
endmodule

// File: tb/tb_ser_video_rx.sv
// Directed bench for ser_video_rx: words of varying length, same-cycle CLK/LAT,
// line measurement with saturation, partial word at idle, and reset mid-word.
module tb_ser_video_rx;
    logic CLK_24M = 1'b0;
    logic nRESET  = 1'b0;

    ser_video_rx_if #(.BITS(7)) vif ();

    ser_video_rx #(
        .BITS        (7),
        .SYNC_STAGES (2),
        .IDLE_TIMEOUT(64)
    ) dut (
        .CLK_24M(CLK_24M),
        .nRESET (nRESET),
        .vid    (vif.slave)
    );

    always #5 CLK_24M = ~CLK_24M;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pix_n    = 0;
    int err_n    = 0;
    int line_n   = 0;
    int line_cyc = 0;
    int last_clk_cyc = 0;

    always @(posedge CLK_24M) cyc++;

    always @(negedge CLK_24M) begin
        if (vif.PIX_STB) pix_n++;
        if (vif.FRAME_ERR) err_n++;
        if (vif.LINE_STB) begin
            line_n++;
            line_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_24M);
    endtask

    task automatic send_bit(input logic r, input logic g, input logic b);
        vif.VIDEO_CLK_SER = 1'b0;
        vif.VIDEO_R_SER   = r;
        vif.VIDEO_G_SER   = g;
        vif.VIDEO_B_SER   = b;
        tick(2);
        vif.VIDEO_CLK_SER = 1'b1;
        last_clk_cyc      = cyc;
        tick(2);
    endtask

    task automatic send_bits(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(r[i], g[i], b[i]);
    endtask

    task automatic pulse_lat();
        vif.VIDEO_CLK_SER = 1'b0;
        vif.VIDEO_LAT_SER = 1'b1;
        tick(2);
        vif.VIDEO_LAT_SER = 1'b0;
        tick(2);
    endtask

    task automatic send_word(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input int nbits);
        send_bits(r, g, b, nbits);
        pulse_lat();
    endtask

    task automatic check_pix(input string tag, input logic [6:0] r, input logic [6:0] g,
                             input logic [6:0] b);
        check_eq({tag, "_r"}, 32'(vif.VIDEO_R), 32'(r));
        check_eq({tag, "_g"}, 32'(vif.VIDEO_G), 32'(g));
        check_eq({tag, "_b"}, 32'(vif.VIDEO_B), 32'(b));
    endtask

    int p0, e0, l0;
    logic [7:0] wr, wg, wb;

    initial begin
        vif.VIDEO_R_SER   = 1'b0;
        vif.VIDEO_G_SER   = 1'b0;
        vif.VIDEO_B_SER   = 1'b0;
        vif.VIDEO_CLK_SER = 1'b0;
        vif.VIDEO_LAT_SER = 1'b0;
        tick(3);
        check_pix("reset", 7'h00, 7'h00, 7'h00);
        check_eq("reset_pix_stb", 32'(vif.PIX_STB), 32'd0);
        check_eq("reset_line_pixels", 32'(vif.LINE_PIXELS), 32'd0);
        nRESET = 1'b1;
        tick(80);
        check_eq("no_line_before_clk", 32'(line_n), 32'd0);

        // Good word with exact strobe latency: k is the first edge seeing LAT high.
        p0 = pix_n; e0 = err_n;
        send_bits(8'h55, 8'h2A, 8'h7F, 7);
        vif.VIDEO_CLK_SER = 1'b0;
        vif.VIDEO_LAT_SER = 1'b1;
        @(posedge CLK_24M);
        @(posedge CLK_24M); #1;
        check_eq("good_stb_k1", 32'(vif.PIX_STB), 32'd0);
        @(posedge CLK_24M); #1;
        check_eq("good_stb_k2", 32'(vif.PIX_STB), 32'd1);
        check_pix("good", 7'h55, 7'h2A, 7'h7F);
        @(posedge CLK_24M); #1;
        check_eq("good_stb_k3", 32'(vif.PIX_STB), 32'd0);
        @(negedge CLK_24M);
        vif.VIDEO_LAT_SER = 1'b0;
        tick(80);
        check_eq("good_pix_count", 32'(pix_n - p0), 32'd1);
        check_eq("good_no_err", 32'(err_n - e0), 32'd0);
        check_eq("good_line_pixels", 32'(vif.LINE_PIXELS), 32'd1);

        // Short and long words are discarded, then a good word recovers.
        p0 = pix_n; e0 = err_n;
        send_word(8'h3F, 8'h00, 8'h15, 6);
        send_word(8'hFF, 8'hA5, 8'h5A, 8);
        tick(6);
        check_eq("shortlong_err", 32'(err_n - e0), 32'd2);
        check_eq("shortlong_no_pix", 32'(pix_n - p0), 32'd0);
        check_pix("shortlong_hold", 7'h55, 7'h2A, 7'h7F);
        send_word(8'h01, 8'h40, 8'h33, 7);
        tick(6);
        check_eq("recover_pix", 32'(pix_n - p0), 32'd1);
        check_pix("recover", 7'h01, 7'h40, 7'h33);
        tick(80);

        // Seventh CLK rise and LAT rise in the same cycle.
        p0 = pix_n; e0 = err_n;
        send_bits(8'h09, 8'h36, 8'h00, 6);
        vif.VIDEO_CLK_SER = 1'b0;
        vif.VIDEO_R_SER   = 1'b1;
        vif.VIDEO_G_SER   = 1'b0;
        vif.VIDEO_B_SER   = 1'b1;
        tick(2);
        vif.VIDEO_CLK_SER = 1'b1;
        vif.VIDEO_LAT_SER = 1'b1;
        tick(2);
        vif.VIDEO_CLK_SER = 1'b0;
        vif.VIDEO_LAT_SER = 1'b0;
        tick(6);
        check_eq("samecyc_pix", 32'(pix_n - p0), 32'd1);
        check_eq("samecyc_err", 32'(err_n - e0), 32'd0);
        check_pix("samecyc", 7'h13, 7'h6C, 7'h01);
        tick(80);

        // 320-pixel line; LINE_STB lands IDLE_TIMEOUT after the registered CLK rise,
        // which is 3 edges after the bench raises CLK (2 sync + 1 detect).
        p0 = pix_n; l0 = line_n;
        for (int i = 0; i < 320; i++) begin
            wr = 8'(i); wg = ~8'(i); wb = 8'(i >> 2);
            send_word(wr, wg, wb, 7);
        end
        tick(70);
        check_eq("line_pix_count", 32'(pix_n - p0), 32'd320);
        check_eq("line_stb_count", 32'(line_n - l0), 32'd1);
        check_eq("line_pixels_320", 32'(vif.LINE_PIXELS), 32'd320);
        check_eq("line_stb_delay", 32'(line_cyc - last_clk_cyc), 32'd67);
        check_pix("line_last", 7'h3F, 7'h40, 7'h4F);
        tick(100);
        check_eq("line_no_second_stb", 32'(line_n - l0), 32'd1);

        l0 = line_n;
        for (int i = 0; i < 600; i++) begin
            wr = 8'(i); wg = ~8'(i); wb = 8'(i >> 2);
            send_word(wr, wg, wb, 7);
        end
        tick(80);
        check_eq("sat_stb_count", 32'(line_n - l0), 32'd1);
        check_eq("sat_line_pixels", 32'(vif.LINE_PIXELS), 32'd511);

        // Partial word at idle with no pixels pending.
        e0 = err_n; l0 = line_n;
        send_bits(8'h07, 8'h07, 8'h07, 3);
        vif.VIDEO_CLK_SER = 1'b0;
        tick(70);
        check_eq("partial_err", 32'(err_n - e0), 32'd1);
        check_eq("partial_no_line", 32'(line_n - l0), 32'd0);
        check_pix("partial_hold", 7'h57, 7'h28, 7'h15);

        // Reset mid-word.
        p0 = pix_n; e0 = err_n; l0 = line_n;
        send_bits(8'h0F, 8'h0F, 8'h0F, 4);
        nRESET = 1'b0;
        #1;
        check_pix("rst_mid", 7'h00, 7'h00, 7'h00);
        check_eq("rst_mid_line_pixels", 32'(vif.LINE_PIXELS), 32'd0);
        vif.VIDEO_CLK_SER = 1'b0;
        tick(3);
        nRESET = 1'b1;
        tick(4);
        check_eq("rst_mid_no_strobes", 32'((pix_n - p0) + (err_n - e0) + (line_n - l0)), 32'd0);
        send_word(8'h2B, 8'h64, 8'h1D, 7);
        tick(6);
        check_eq("rst_recover_pix", 32'(pix_n - p0), 32'd1);
        check_eq("rst_recover_err", 32'(err_n - e0), 32'd0);
        check_pix("rst_recover", 7'h2B, 7'h64, 7'h1D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
